// File: rtl/lane_scene_renderer.sv
// Per-pixel lane/traffic/player compositor with overlap detection and the
// IDLE/RUN/CRASH/OVER game sequencer. One register stage between counts and rgb.
module lane_scene_renderer #(
  parameter int          H_ACTIVE     = 640,
  parameter int          V_ACTIVE     = 480,
  parameter int          N_LANES      = 3,
  parameter int          LANE_W       = 207,
  parameter int          BORDER_W     = 5,
  parameter int          N_SLOTS      = 4,
  parameter int          OBJ_W        = 80,
  parameter int          OBJ_H        = 80,
  parameter int          DASH_LEN     = 32,
  parameter int          FLASH_FRAMES = 16,
  parameter logic [23:0] C_LANE       = 24'hFFFFFF,
  parameter logic [23:0] C_DASH       = 24'hFFFF00,
  parameter logic [23:0] C_TRAFFIC    = 24'hFF0000,
  parameter logic [23:0] C_PLAYER     = 24'h0000FF,
  parameter logic [23:0] C_CRASH      = 24'hFF00FF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [9:0]             h_count,
  input  logic [9:0]             v_count,
  input  logic                   frame_tick,
  input  logic                   start,
  input  logic [3:0]             scroll_step,
  input  logic [9:0]             player_x,
  input  logic [9:0]             player_y,
  input  logic [N_SLOTS-1:0]     slot_active,
  input  logic [2*N_SLOTS-1:0]   slot_lane,
  input  logic [10*N_SLOTS-1:0]  slot_y,
  output logic [23:0]            rgb,
  output logic                   game_active,
  output logic [1:0]             state,
  output logic                   collision,
  output logic [N_SLOTS-1:0]     hit_slot
);

  localparam int SW    = $clog2(2 * DASH_LEN);
  localparam int FW    = $clog2(FLASH_FRAMES + 1);
  localparam int PITCH = LANE_W + BORDER_W;
  localparam int OFS   = (LANE_W - OBJ_W) / 2;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, CRASH = 2'd2, OVER = 2'd3} state_t;

  state_t             state_q, state_d;
  logic [SW-1:0]      scroll_q, scroll_d;
  logic [FW-1:0]      flash_q, flash_d;
  logic [N_SLOTS-1:0] hit_acc_q, hit_acc_d;
  logic [N_SLOTS-1:0] hit_slot_q, hit_slot_d;
  logic               collision_q, collision_d;
  logic [23:0]        rgb_q, rgb_d;

  logic [10:0]        hx, vy;
  logic               active_px;
  logic               in_lane, in_div, in_player, dash_on;
  logic [N_SLOTS-1:0] in_slot;
  logic signed [11:0] hs, pl_l, pl_r;
  logic [SW-1:0]      dphase;
  logic [FW-1:0]      flash_el;
  logic [23:0]        player_col;

  assign hx        = {1'b0, h_count};
  assign vy        = {1'b0, v_count};
  assign active_px = (hx < 11'(H_ACTIVE)) && (vy < 11'(V_ACTIVE));

  always_comb begin
    in_lane = 1'b0;
    in_div  = 1'b0;
    for (int k = 0; k < N_LANES; k++) begin
      if (hx >= 11'(k * PITCH) && hx < 11'(k * PITCH + LANE_W)) in_lane = 1'b1;
      if (k < N_LANES - 1 && hx >= 11'(k * PITCH + LANE_W) && hx < 11'((k + 1) * PITCH))
        in_div = 1'b1;
    end
  end

  // Bounds in 11 bits so an object near the bottom clips instead of wrapping to the top.
  always_comb begin
    logic [10:0] sx, sy;
    sx      = '0;
    sy      = '0;
    in_slot = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      sx = 11'(OFS) + 11'(PITCH) * {9'd0, slot_lane[2*i +: 2]};
      sy = {1'b0, slot_y[10*i +: 10]};
      if (slot_active[i] && int'(slot_lane[2*i +: 2]) < N_LANES)
        in_slot[i] = (hx >= sx) && (hx < sx + 11'(OBJ_W)) &&
                     (vy >= sy) && (vy < sy + 11'(OBJ_H));
    end
  end

  assign hs        = $signed({2'b00, h_count});
  assign pl_l      = $signed({2'b00, player_x}) - $signed(12'(OBJ_W / 2));
  assign pl_r      = $signed({2'b00, player_x}) + $signed(12'(OBJ_W / 2));
  assign in_player = (hs >= pl_l) && (hs < pl_r) &&
                     (vy >= {1'b0, player_y}) && (vy < {1'b0, player_y} + 11'(OBJ_H));

  // Dash period is a power of two, so the top phase bit selects dash vs gap.
  assign dphase  = v_count[SW-1:0] - scroll_q;
  assign dash_on = ~dphase[SW-1];

  assign flash_el = FW'(FLASH_FRAMES - 1) - flash_q;

  always_comb begin
    player_col = C_PLAYER;
    if (state_q == OVER)       player_col = C_CRASH;
    else if (state_q == CRASH) player_col = flash_el[1] ? C_PLAYER : C_CRASH;
  end

  always_comb begin
    rgb_d = 24'h000000;
    if (active_px) begin
      if (in_player)     rgb_d = player_col;
      else if (|in_slot) rgb_d = C_TRAFFIC;
      else if (in_div)   rgb_d = dash_on ? C_DASH : 24'h000000;
      else if (in_lane)  rgb_d = C_LANE;
    end
  end

  always_comb begin
    state_d     = state_q;
    scroll_d    = scroll_q;
    flash_d     = flash_q;
    hit_slot_d  = hit_slot_q;
    collision_d = 1'b0;
    hit_acc_d   = frame_tick ? '0 : hit_acc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          scroll_d = '0;
        end
      end
      RUN: begin
        if (!frame_tick && active_px)
          hit_acc_d = hit_acc_q | (in_slot & {N_SLOTS{in_player}});
        if (frame_tick) begin
          if (|hit_acc_q) begin
            state_d     = CRASH;
            hit_slot_d  = hit_acc_q;
            collision_d = 1'b1;
            flash_d     = FW'(FLASH_FRAMES - 1);
          end else begin
            scroll_d = scroll_q + SW'(scroll_step);
          end
        end
      end
      CRASH: begin
        if (frame_tick) begin
          if (flash_q == '0) state_d = OVER;
          else               flash_d = flash_q - 1'b1;
        end
      end
      OVER: begin
        if (start) begin
          state_d    = RUN;
          scroll_d   = '0;
          hit_slot_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      scroll_q    <= '0;
      flash_q     <= '0;
      hit_acc_q   <= '0;
      hit_slot_q  <= '0;
      collision_q <= 1'b0;
      rgb_q       <= 24'h000000;
    end else begin
      state_q     <= state_d;
      scroll_q    <= scroll_d;
      flash_q     <= flash_d;
      hit_acc_q   <= hit_acc_d;
      hit_slot_q  <= hit_slot_d;
      collision_q <= collision_d;
      rgb_q       <= rgb_d;
    end
  end

  assign rgb         = rgb_q;
  assign state       = state_q;
  assign game_active = (state_q == RUN);
  assign collision   = collision_q;
  assign hit_slot    = hit_slot_q;

endmodule

// File: tb/tb_lane_scene_renderer.sv
// Directed bench for lane_scene_renderer: compressed "frames" of probe pixels,
// a geometric reference model checked every cycle, plus literal pixel/state checks.
module tb_lane_scene_renderer;

  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] YEL   = 24'hFFFF00;
  localparam logic [23:0] RED   = 24'hFF0000;
  localparam logic [23:0] BLUE  = 24'h0000FF;
  localparam logic [23:0] MAG   = 24'hFF00FF;
  localparam logic [23:0] BLACK = 24'h000000;
  localparam int NP = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  h_count = 10'd700, v_count = 10'd500;
  logic        frame_tick = 1'b0, start = 1'b0;
  logic [3:0]  scroll_step = 4'd0;
  logic [9:0]  player_x = 10'd0, player_y = 10'd0;
  logic [3:0]  slot_active = 4'd0;
  logic [7:0]  slot_lane = 8'd0;
  logic [39:0] slot_y = 40'd0;
  logic [23:0] rgb;
  logic        game_active, collision;
  logic [1:0]  state;
  logic [3:0]  hit_slot;

  int n_checks = 0;
  int n_err    = 0;
  int col_cnt  = 0;

  int ph[NP] = '{300, 316, 100, 209, 209, 209, 209, 100, 275, 500, 500, 500, 639, 0, 40, 631};
  int pv[NP] = '{220, 200, 40, 0, 1, 32, 33, 100, 220, 470, 479, 480, 0, 10, 10, 5};

  lane_scene_renderer dut (
    .clk(clk), .rst(rst), .h_count(h_count), .v_count(v_count),
    .frame_tick(frame_tick), .start(start), .scroll_step(scroll_step),
    .player_x(player_x), .player_y(player_y), .slot_active(slot_active),
    .slot_lane(slot_lane), .slot_y(slot_y), .rgb(rgb), .game_active(game_active),
    .state(state), .collision(collision), .hit_slot(hit_slot)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (screen geometry in plain integers) ----
  logic [1:0]  m_state;
  int          m_scroll, m_flash;
  logic [3:0]  m_acc, m_hit;
  logic [23:0] e_rgb;
  logic        e_col;

  function automatic bit on_player(int h, int v);
    int x0 = int'(player_x) - 40;
    if (x0 < 0) x0 = 0;
    return h >= x0 && h < int'(player_x) + 40 && v >= int'(player_y) && v < int'(player_y) + 80;
  endfunction

  function automatic bit on_slot(int i, int h, int v);
    int ln = int'(slot_lane[2*i +: 2]);
    int x0 = ln * 212 + 63;
    int y0 = int'(slot_y[10*i +: 10]);
    if (!slot_active[i] || ln >= 3) return 1'b0;
    return h >= x0 && h < x0 + 80 && v >= y0 && v < y0 + 80;
  endfunction

  function automatic logic [23:0] model_pix(int h, int v);
    int d;
    if (h >= 640 || v >= 480) return BLACK;
    if (on_player(h, v)) begin
      if (m_state == 2'd3) return MAG;
      if (m_state == 2'd2) return ((m_flash / 2) % 2 == 0) ? MAG : BLUE;
      return BLUE;
    end
    for (int i = 0; i < 4; i++) if (on_slot(i, h, v)) return RED;
    if (h >= 631) return BLACK;
    if (h % 212 < 207) return WHITE;
    d = ((v - m_scroll) % 64 + 64) % 64;
    return (d < 32) ? YEL : BLACK;
  endfunction

  function automatic logic [3:0] model_hits(int h, int v);
    logic [3:0] r = 4'd0;
    if (h >= 640 || v >= 480 || !on_player(h, v)) return r;
    for (int i = 0; i < 4; i++) if (on_slot(i, h, v)) r[i] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state <= 2'd0; m_scroll <= 0; m_flash <= 0;
      m_acc <= 4'd0; m_hit <= 4'd0; e_rgb <= BLACK; e_col <= 1'b0;
    end else begin
      e_rgb <= model_pix(int'(h_count), int'(v_count));
      e_col <= 1'b0;
      if (frame_tick) m_acc <= 4'd0;
      else if (m_state == 2'd1) m_acc <= m_acc | model_hits(int'(h_count), int'(v_count));
      case (m_state)
        2'd0: if (start) begin m_state <= 2'd1; m_scroll <= 0; end
        2'd1: if (frame_tick) begin
          if (m_acc != 4'd0) begin
            m_state <= 2'd2; m_hit <= m_acc; e_col <= 1'b1; m_flash <= 0;
          end else m_scroll <= (m_scroll + int'(scroll_step)) % 64;
        end
        2'd2: if (frame_tick) begin
          if (m_flash + 1 == 16) m_state <= 2'd3;
          m_flash <= m_flash + 1;
        end
        default: if (start) begin m_state <= 2'd1; m_scroll <= 0; m_hit <= 4'd0; end
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rgb", 32'(rgb), 32'(e_rgb));
      chk("state", 32'(state), 32'(m_state));
      chk("game_active", 32'(game_active), 32'(m_state == 2'd1));
      chk("collision", 32'(collision), 32'(e_col));
      chk("hit_slot", 32'(hit_slot), 32'(m_hit));
      if (collision) col_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic drive(input int h, input int v, input logic ft, input logic st);
    @(posedge clk);
    #1;
    h_count = 10'(h); v_count = 10'(v); frame_tick = ft; start = st;
  endtask

  task automatic pix_lit(input int h, input int v, input logic [23:0] e, input string nm);
    drive(h, v, 1'b0, 1'b0);
    drive(700, 500, 1'b0, 1'b0);
    @(negedge clk);
    chk(nm, 32'(rgb), 32'(e));
  endtask

  task automatic frame(input logic st_on_tick);
    for (int i = 0; i < NP; i++) drive(ph[i], pv[i], 1'b0, 1'b0);
    drive(700, 500, 1'b1, st_on_tick);
    drive(700, 500, 1'b0, 1'b0);
  endtask

  task automatic pulse_start();
    drive(700, 500, 1'b0, 1'b1);
    drive(700, 500, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  // ---------------- directed sequence ---------------------------------------
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rgb", 32'(rgb), 32'h0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_hit_slot", 32'(hit_slot), 32'd0);
    #3 rst = 1'b1;

    // idle sweep, player at x=0 clipped to [0,40)
    pix_lit(100, 100, WHITE, "lane0_100_100");
    pix_lit(209, 10,  YEL,   "dash_209_10");
    pix_lit(209, 40,  BLACK, "gap_209_40");
    pix_lit(639, 0,   BLACK, "right_black");
    pix_lit(0, 10,    BLUE,  "player_left_clip");
    pix_lit(39, 10,   BLUE,  "player_last_col");
    pix_lit(40, 10,   WHITE, "player_past_right");
    pix_lit(630, 5,   WHITE, "lane2_last_col");
    pix_lit(631, 5,   BLACK, "past_last_lane");
    pix_lit(212, 0,   WHITE, "lane1_first_col");
    frame(1'b0);

    // traffic in lane 1, an ignored slot in lane 3, a slot clipped at the bottom
    slot_active = 4'b0111;
    slot_lane   = {2'd0, 2'd2, 2'd3, 2'd1};
    slot_y      = {10'd0, 10'd440, 10'd200, 10'd200};
    player_x = 10'd100; player_y = 10'd0; scroll_step = 4'd3;
    pulse_start();
    chk("start_run", 32'(state), 32'd1);
    repeat (4) frame(1'b0);
    pix_lit(275, 220, RED,   "traffic_275_220");
    pix_lit(274, 220, WHITE, "traffic_left_edge");
    pix_lit(354, 279, RED,   "traffic_bottom_right");
    pix_lit(500, 479, RED,   "slot_bottom_clip");
    pix_lit(500, 480, BLACK, "below_active");
    pix_lit(100, 40,  BLUE,  "player_run");
    chk("no_collision_yet", 32'(col_cnt), 32'd0);
    chk("still_run", 32'(state), 32'd1);

    // overlap -> crash
    player_x = 10'd316; player_y = 10'd190;
    frame(1'b0);
    @(negedge clk);
    chk("crash_pulse", 32'(collision), 32'd1);
    chk("crash_hit_slot", 32'(hit_slot), 32'h1);
    chk("crash_state", 32'(state), 32'd2);
    drive(700, 500, 1'b0, 1'b0);
    @(negedge clk);
    chk("crash_pulse_end", 32'(collision), 32'd0);
    pulse_start();
    chk("start_ignored_crash", 32'(state), 32'd2);

    for (int f = 0; f < 16; f++) begin
      pix_lit(316, 200, ((f / 2) % 2 == 0) ? MAG : BLUE, "flash_colour");
      frame(1'b0);
    end
    chk("over_state", 32'(state), 32'd3);
    pix_lit(316, 200, MAG, "over_colour");
    chk("one_collision", 32'(col_cnt), 32'd1);

    // restart from OVER: hit_slot and scroll clear
    player_x = 10'd100; player_y = 10'd0; scroll_step = 4'd5;
    pulse_start();
    chk("restart_run", 32'(state), 32'd1);
    chk("restart_hit_clear", 32'(hit_slot), 32'd0);
    pix_lit(209, 0,  YEL,   "scroll0_line0");
    pix_lit(209, 31, YEL,   "scroll0_line31");
    pix_lit(209, 32, BLACK, "scroll0_line32");

    repeat (13) frame(1'b0);
    pix_lit(209, 0,  BLACK, "scroll1_line0");
    pix_lit(209, 1,  YEL,   "scroll1_line1");
    pix_lit(209, 32, YEL,   "scroll1_line32");
    pix_lit(209, 33, BLACK, "scroll1_line33");

    // crash again, then async reset mid-line
    player_x = 10'd316; player_y = 10'd190;
    frame(1'b0);
    @(negedge clk);
    chk("crash2_state", 32'(state), 32'd2);
    drive(300, 220, 1'b0, 1'b0);
    drive(316, 200, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("arst_rgb", 32'(rgb), 32'h0);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_active", 32'(game_active), 32'd0);
    chk("arst_collision", 32'(collision), 32'd0);
    chk("arst_hit_slot", 32'(hit_slot), 32'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    player_x = 10'd100; player_y = 10'd0;

    // start together with frame_tick in IDLE: RUN, no scroll advance
    drive(700, 500, 1'b1, 1'b1);
    drive(700, 500, 1'b0, 1'b0);
    @(negedge clk);
    chk("idle_start_tick", 32'(state), 32'd1);
    pix_lit(209, 0, YEL, "no_advance_on_entry");

    // hits plus start on the same frame_tick in RUN: crash wins
    player_x = 10'd316; player_y = 10'd190;
    frame(1'b1);
    @(negedge clk);
    chk("crash_over_start", 32'(state), 32'd2);
    chk("crash_over_start_pulse", 32'(collision), 32'd1);

    drive(700, 500, 1'b0, 1'b0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
